// File: rtl/mac_frame_splitter_pkg.sv
// Shared definitions for the MAC frame splitter: FSM state encoding,
// Ethernet header lengths and the 802.1Q tag protocol identifier.
package mac_frame_splitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_COMMIT  = 3'd4,
    ST_DROP    = 3'd5
  } state_e;

  localparam int          ETH_HDR_LEN  = 14;
  localparam int          VLAN_HDR_LEN = 18;
  localparam logic [15:0] TPID_VLAN    = 16'h8100;

endpackage

// File: rtl/mac_frame_splitter_rdpipe.sv
// mac_fifo_rdpipe: read side of the PHY RX FIFO.
//   rd_allow      in  : the frame FSM wants bytes
//   i_fifo_*      in  : PHY FIFO data/last-byte flag (1 cycle after rden), empty
//   i_fifo_rden   out : PHY FIFO read strobe
//   rd_vld/data/del out : registered byte, valid for one cycle
// At most one read is outstanding; once the last byte of a frame is seen
// no further reads are issued until rd_allow drops.
module mac_fifo_rdpipe (
  input  logic       clk,
  input  logic       arst,
  input  logic       rd_allow,
  input  logic [7:0] i_fifo_dout,
  input  logic       i_fifo_del,
  input  logic       i_fifo_empty,
  output logic       i_fifo_rden,
  output logic       rd_vld,
  output logic [7:0] rd_data,
  output logic       rd_del
);

  logic       pend_q, pend_d;
  logic       vld_q, vld_d;
  logic [7:0] data_q, data_d;
  logic       del_q, del_d;
  logic       done_q, done_d;
  logic       del_back;

  // pend_q marks the cycle in which the FIFO presents the requested byte
  assign del_back = pend_q & i_fifo_del;

  always_comb begin
    i_fifo_rden = rd_allow & ~i_fifo_empty & ~done_q & ~del_back;
    pend_d      = i_fifo_rden;
    vld_d       = pend_q;
    data_d      = pend_q ? i_fifo_dout : data_q;
    del_d       = del_back;
    done_d      = rd_allow & (done_q | del_back);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pend_q <= 1'b0;
      vld_q  <= 1'b0;
      data_q <= '0;
      del_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      vld_q  <= vld_d;
      data_q <= data_d;
      del_q  <= del_d;
      done_q <= done_d;
    end
  end

  assign rd_vld  = vld_q;
  assign rd_data = data_q;
  assign rd_del  = del_q;

endmodule

// File: rtl/mac_frame_splitter.sv
// mac_frame_splitter: splits PHY RX frames into an L2 header record and a
// payload byte stream, with length checking and bad-frame discard.
//   clk, arst                 : clock, async active-high reset
//   i_fifo_dout/del/empty/rden: PHY RX FIFO read port
//   h_fifo_din/full/wren      : header record {tagged, payload_len, header bytes}
//   b_fifo_din/eof/afull/wren : payload bytes, eof on last byte of a good frame
//   b_fifo_drop               : discard payload written since last eof
//   ok_cnt/err_cnt            : saturating good/discarded frame counters
module mac_frame_splitter
  import mac_frame_splitter_pkg::*;
#(
  parameter  int TAG_EN  = 1,
  parameter  int MIN_LEN = 60,
  parameter  int MAX_LEN = 1518,
  parameter  int LEN_W   = 11,
  parameter  int CNT_W   = 16,
  localparam int HB      = (TAG_EN != 0) ? VLAN_HDR_LEN : ETH_HDR_LEN,
  localparam int HW      = 1 + LEN_W + 8 * HB
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [7:0]       i_fifo_dout,
  input  logic             i_fifo_del,
  input  logic             i_fifo_empty,
  output logic             i_fifo_rden,
  output logic [HW-1:0]    h_fifo_din,
  input  logic             h_fifo_full,
  output logic             h_fifo_wren,
  output logic [7:0]       b_fifo_din,
  output logic             b_fifo_eof,
  input  logic             b_fifo_afull,
  output logic             b_fifo_wren,
  output logic             b_fifo_drop,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int N_W = $clog2(MAX_LEN + 1);

  state_e            state_q, state_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [8*HB-1:0]   hdr_q, hdr_d;
  logic              tagged_q, tagged_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              bwren_q, bwren_d;
  logic [7:0]        bdin_q, bdin_d;
  logic              beof_q, beof_d;
  logic [CNT_W-1:0]  ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic              rd_allow;
  logic              rd_vld;
  logic [7:0]        rd_data;
  logic              rd_del;
  logic [N_W-1:0]    n_inc;
  logic [N_W-1:0]    hdr_tgt;
  logic [N_W-1:0]    hdr_len;
  logic              tag_hit;

  assign rd_allow = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD) ||
                    (state_q == ST_FLUSH);

  mac_fifo_rdpipe u_rdpipe (
    .clk          (clk),
    .arst         (arst),
    .rd_allow     (rd_allow),
    .i_fifo_dout  (i_fifo_dout),
    .i_fifo_del   (i_fifo_del),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_rden  (i_fifo_rden),
    .rd_vld       (rd_vld),
    .rd_data      (rd_data),
    .rd_del       (rd_del)
  );

  // n_inc is the total frame length including the byte now being consumed
  assign n_inc   = n_q + N_W'(1);
  assign hdr_len = tagged_q ? N_W'(VLAN_HDR_LEN) : N_W'(ETH_HDR_LEN);
  // byte 12 already sits in the header register when byte 13 arrives
  assign tag_hit = (TAG_EN != 0) && (n_q == N_W'(13)) &&
                   ({hdr_q[8*(HB-13) +: 8], rd_data} == TPID_VLAN);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    hdr_d     = hdr_q;
    tagged_d  = tagged_q;
    len_d     = len_q;
    bwren_d   = 1'b0;
    bdin_d    = bdin_q;
    beof_d    = 1'b0;
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    hdr_tgt   = N_W'(ETH_HDR_LEN);

    case (state_q)
      ST_IDLE: begin
        n_d = '0;
        if (!i_fifo_empty && !h_fifo_full && !b_fifo_afull)
          state_d = ST_HEADER;
      end

      ST_HEADER: begin
        if (rd_vld) begin
          // the committed record of the previous frame is held until now
          if (n_q == '0) begin
            hdr_d    = '0;
            tagged_d = 1'b0;
            len_d    = '0;
          end
          for (int unsigned i = 0; i < HB; i++)
            if (n_q == N_W'(i)) hdr_d[8*(HB-1-i) +: 8] = rd_data;
          if (tag_hit) tagged_d = 1'b1;
          hdr_tgt = tagged_d ? N_W'(VLAN_HDR_LEN) : N_W'(ETH_HDR_LEN);
          n_d     = n_inc;
          if (rd_del)
            state_d = ST_DROP;
          else if (n_inc == hdr_tgt)
            state_d = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (rd_vld) begin
          n_d = n_inc;
          if (rd_del) begin
            if (n_inc >= N_W'(MIN_LEN) && n_inc <= N_W'(MAX_LEN)) begin
              bwren_d = 1'b1;
              beof_d  = 1'b1;
              bdin_d  = rd_data;
              len_d   = LEN_W'(n_inc - hdr_len);
              state_d = ST_COMMIT;
            end else begin
              state_d = ST_DROP;
            end
          end else begin
            bwren_d = 1'b1;
            bdin_d  = rd_data;
            if (n_inc == N_W'(MAX_LEN)) state_d = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        if (rd_vld && rd_del) state_d = ST_DROP;
      end

      ST_COMMIT: begin
        if (ok_cnt_q != '1) ok_cnt_d = ok_cnt_q + CNT_W'(1);
        state_d = ST_IDLE;
      end

      ST_DROP: begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      hdr_q     <= '0;
      tagged_q  <= 1'b0;
      len_q     <= '0;
      bwren_q   <= 1'b0;
      bdin_q    <= '0;
      beof_q    <= 1'b0;
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      hdr_q     <= hdr_d;
      tagged_q  <= tagged_d;
      len_q     <= len_d;
      bwren_q   <= bwren_d;
      bdin_q    <= bdin_d;
      beof_q    <= beof_d;
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // the eof body write lands in the same cycle as the header write
  assign h_fifo_din  = {tagged_q, len_q, hdr_q};
  assign h_fifo_wren = (state_q == ST_COMMIT);
  assign b_fifo_drop = (state_q == ST_DROP);
  assign b_fifo_wren = bwren_q;
  assign b_fifo_din  = bdin_q;
  assign b_fifo_eof  = beof_q;
  assign ok_cnt      = ok_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_mac_frame_splitter.sv
module tb_mac_frame_splitter;

  logic         clk = 1'b0;
  logic         arst = 1'b1;
  logic [7:0]   i_fifo_dout = '0;
  logic         i_fifo_del = 1'b0;
  logic         i_fifo_empty = 1'b1;
  logic         i_fifo_rden;
  logic [155:0] h_fifo_din;
  logic         h_fifo_full = 1'b0;
  logic         h_fifo_wren;
  logic [7:0]   b_fifo_din;
  logic         b_fifo_eof;
  logic         b_fifo_afull = 1'b0;
  logic         b_fifo_wren;
  logic         b_fifo_drop;
  logic [15:0]  ok_cnt;
  logic [15:0]  err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]   phy_q[$];
  logic [8:0]   body_q[$];
  int           h_cnt = 0;
  int           drop_cnt = 0;
  int           rden_cnt = 0;
  int           rden_empty = 0;
  logic [155:0] h_last = '0;
  bit           toggle_en = 0;
  bit           stall = 0;
  int           tcnt = 0;

  mac_frame_splitter #(
    .TAG_EN (1),
    .MIN_LEN(60),
    .MAX_LEN(1518),
    .LEN_W  (11),
    .CNT_W  (16)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .i_fifo_dout  (i_fifo_dout),
    .i_fifo_del   (i_fifo_del),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_rden  (i_fifo_rden),
    .h_fifo_din   (h_fifo_din),
    .h_fifo_full  (h_fifo_full),
    .h_fifo_wren  (h_fifo_wren),
    .b_fifo_din   (b_fifo_din),
    .b_fifo_eof   (b_fifo_eof),
    .b_fifo_afull (b_fifo_afull),
    .b_fifo_wren  (b_fifo_wren),
    .b_fifo_drop  (b_fifo_drop),
    .ok_cnt       (ok_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  // PHY FIFO model: a read taken at a clock edge returns its byte just after that edge
  initial begin
    bit req;
    forever begin
      @(negedge clk);
      req = i_fifo_rden;
      if (req) rden_cnt++;
      if (req && i_fifo_empty) rden_empty++;
      @(posedge clk);
      #1;
      if (req && phy_q.size() > 0) {i_fifo_del, i_fifo_dout} = phy_q.pop_front();
      if (toggle_en) begin
        tcnt++;
        if (tcnt == 3) begin
          stall = ~stall;
          tcnt  = 0;
        end
      end else begin
        stall = 0;
        tcnt  = 0;
      end
      i_fifo_empty = (phy_q.size() == 0) || stall;
    end
  end

  // output capture for the HEADER/BODY FIFOs
  always @(negedge clk) begin
    if (!arst) begin
      if (b_fifo_wren) body_q.push_back({b_fifo_eof, b_fifo_din});
      if (h_fifo_wren) begin
        h_cnt++;
        h_last = h_fifo_din;
      end
      if (b_fifo_drop) drop_cnt++;
    end
  end

  task automatic clear_mon();
    body_q.delete();
    h_cnt      = 0;
    drop_cnt   = 0;
    rden_cnt   = 0;
    rden_empty = 0;
  endtask

  task automatic push_frame(input int len, input bit tag);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = i[7:0];
      if (tag && i == 12) b = 8'h81;
      if (tag && i == 13) b = 8'h00;
      phy_q.push_back({(i == len - 1), b});
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    int h0, d0, k;
    h0 = h_cnt;
    d0 = drop_cnt;
    k  = 0;
    while (h_cnt == h0 && drop_cnt == d0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    n_tests++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: no commit/drop after %0d cycles (required within budget)", name, budget);
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({i_fifo_rden, h_fifo_wren, b_fifo_wren, b_fifo_drop, b_fifo_eof} !== 5'b0 ||
        h_fifo_din !== '0 || b_fifo_din !== 8'h00 || ok_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: rden=%b hwren=%b bwren=%b drop=%b ok=%0d err=%0d hdin=%h (required all 0)",
               i_fifo_rden, h_fifo_wren, b_fifo_wren, b_fifo_drop, ok_cnt, err_cnt, h_fifo_din);
    end
    @(negedge clk);
    arst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_untagged();
    logic [143:0] exp_hdr;
    int eofs;
    clear_mon();
    push_frame(64, 0);
    wait_done(300, "untagged");
    exp_hdr = '0;
    for (int i = 0; i < 14; i++) exp_hdr[8*(17-i) +: 8] = i[7:0];
    n_tests++;
    if (body_q.size() != 50) begin
      n_fail++;
      $display("FAIL untagged_body_count: got %0d required 50", body_q.size());
    end
    eofs = 0;
    for (int k = 0; k < body_q.size(); k++) begin
      n_tests++;
      if (body_q[k] !== {(k == 49), 8'(14 + k)}) begin
        n_fail++;
        $display("FAIL untagged_body[%0d]: got %h required %h", k, body_q[k], {(k == 49), 8'(14 + k)});
      end
    end
    n_tests++;
    if (h_cnt != 1) begin n_fail++; $display("FAIL untagged_hwren: got %0d required 1", h_cnt); end
    n_tests++;
    if (h_last[155] !== 1'b0) begin n_fail++; $display("FAIL untagged_tagged: got %b required 0", h_last[155]); end
    n_tests++;
    if (h_last[154:144] !== 11'd50) begin n_fail++; $display("FAIL untagged_len: got %0d required 50", h_last[154:144]); end
    n_tests++;
    if (h_last[143:0] !== exp_hdr) begin n_fail++; $display("FAIL untagged_hdr: got %h required %h", h_last[143:0], exp_hdr); end
    n_tests++;
    if (ok_cnt !== 16'd1) begin n_fail++; $display("FAIL untagged_ok_cnt: got %0d required 1", ok_cnt); end
    n_tests++;
    if (drop_cnt != 0) begin n_fail++; $display("FAIL untagged_drop: got %0d required 0", drop_cnt); end
    n_tests++;
    if (h_fifo_din !== h_last) begin n_fail++; $display("FAIL untagged_hdin_hold: got %h required %h", h_fifo_din, h_last); end
  endtask

  task automatic test_tagged();
    logic [143:0] exp_hdr;
    clear_mon();
    push_frame(68, 1);
    wait_done(300, "tagged");
    for (int i = 0; i < 18; i++) exp_hdr[8*(17-i) +: 8] = i[7:0];
    exp_hdr[8*5 +: 8] = 8'h81;
    exp_hdr[8*4 +: 8] = 8'h00;
    n_tests++;
    if (body_q.size() != 50) begin
      n_fail++;
      $display("FAIL tagged_body_count: got %0d required 50", body_q.size());
    end else begin
      n_tests++;
      if (body_q[0] !== {1'b0, 8'h12} || body_q[49] !== {1'b1, 8'h43}) begin
        n_fail++;
        $display("FAIL tagged_body_ends: got %h..%h required 012..143", body_q[0], body_q[49]);
      end
    end
    n_tests++;
    if (h_cnt != 1 || h_last[155] !== 1'b1) begin
      n_fail++;
      $display("FAIL tagged_flag: hwren=%0d tagged=%b required 1/1", h_cnt, h_last[155]);
    end
    n_tests++;
    if (h_last[154:144] !== 11'd50) begin n_fail++; $display("FAIL tagged_len: got %0d required 50", h_last[154:144]); end
    n_tests++;
    if (h_last[143:0] !== exp_hdr) begin n_fail++; $display("FAIL tagged_hdr: got %h required %h", h_last[143:0], exp_hdr); end
    n_tests++;
    if (ok_cnt !== 16'd2) begin n_fail++; $display("FAIL tagged_ok_cnt: got %0d required 2", ok_cnt); end
  endtask

  task automatic test_runt();
    clear_mon();
    push_frame(10, 0);
    wait_done(100, "runt");
    n_tests++;
    if (body_q.size() != 0 || h_cnt != 0) begin
      n_fail++;
      $display("FAIL runt_writes: body=%0d hdr=%0d required 0/0", body_q.size(), h_cnt);
    end
    n_tests++;
    if (drop_cnt != 1) begin n_fail++; $display("FAIL runt_drop: got %0d required 1", drop_cnt); end
    n_tests++;
    if (err_cnt !== 16'd1 || ok_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL runt_cnts: err=%0d ok=%0d required 1/2", err_cnt, ok_cnt);
    end
  endtask

  task automatic test_oversize();
    int eofs;
    clear_mon();
    push_frame(1600, 0);
    wait_done(2500, "oversize");
    n_tests++;
    if (body_q.size() != 1504) begin
      n_fail++;
      $display("FAIL oversize_body_count: got %0d required 1504", body_q.size());
    end else begin
      n_tests++;
      if (body_q[1503] !== {1'b0, 8'hED}) begin
        n_fail++;
        $display("FAIL oversize_last_byte: got %h required 0ed", body_q[1503]);
      end
    end
    eofs = 0;
    foreach (body_q[k]) if (body_q[k][8]) eofs++;
    n_tests++;
    if (eofs != 0) begin n_fail++; $display("FAIL oversize_eof: got %0d required 0", eofs); end
    n_tests++;
    if (phy_q.size() != 0) begin n_fail++; $display("FAIL oversize_flush: %0d bytes left required 0", phy_q.size()); end
    n_tests++;
    if (drop_cnt != 1 || h_cnt != 0) begin
      n_fail++;
      $display("FAIL oversize_drop: drop=%0d hdr=%0d required 1/0", drop_cnt, h_cnt);
    end
    n_tests++;
    if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL oversize_err_cnt: got %0d required 2", err_cnt); end
  endtask

  task automatic test_stall_hold();
    int bad;
    clear_mon();
    h_fifo_full = 1'b1;
    push_frame(64, 0);
    repeat (20) @(posedge clk);
    n_tests++;
    if (rden_cnt != 0 || body_q.size() != 0) begin
      n_fail++;
      $display("FAIL hold_no_start: rden=%0d body=%0d required 0/0", rden_cnt, body_q.size());
    end
    @(negedge clk);
    h_fifo_full = 1'b0;
    toggle_en   = 1;
    wait_done(600, "stall");
    toggle_en = 0;
    n_tests++;
    if (rden_empty != 0) begin n_fail++; $display("FAIL stall_rden_empty: got %0d required 0", rden_empty); end
    bad = 0;
    foreach (body_q[k]) if (body_q[k] !== {(k == 49), 8'(14 + k)}) bad++;
    n_tests++;
    if (body_q.size() != 50 || bad != 0) begin
      n_fail++;
      $display("FAIL stall_body_order: count=%0d wrong=%0d required 50/0", body_q.size(), bad);
    end
    n_tests++;
    if (ok_cnt !== 16'd3 || h_last[154:144] !== 11'd50) begin
      n_fail++;
      $display("FAIL stall_commit: ok=%0d len=%0d required 3/50", ok_cnt, h_last[154:144]);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    int bad;
    clear_mon();
    push_frame(64, 0);
    k = 0;
    while (body_q.size() < 10 && k < 200) begin
      @(posedge clk);
      k++;
    end
    n_tests++;
    if (k >= 200) begin n_fail++; $display("FAIL rstmid_reach_payload: body=%0d required >=10", body_q.size()); end
    @(negedge clk);
    arst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if ({i_fifo_rden, h_fifo_wren, b_fifo_wren, b_fifo_drop, b_fifo_eof} !== 5'b0 ||
        h_fifo_din !== '0 || b_fifo_din !== 8'h00 || ok_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: rden=%b hwren=%b bwren=%b drop=%b ok=%0d err=%0d (required all 0)",
               i_fifo_rden, h_fifo_wren, b_fifo_wren, b_fifo_drop, ok_cnt, err_cnt);
    end
    repeat (2) @(negedge clk);
    phy_q.delete();
    i_fifo_empty = 1'b1;
    i_fifo_del   = 1'b0;
    arst = 1'b0;
    repeat (3) @(posedge clk);
    clear_mon();
    push_frame(64, 0);
    wait_done(300, "rstmid_clean");
    bad = 0;
    foreach (body_q[j]) if (body_q[j] !== {(j == 49), 8'(14 + j)}) bad++;
    n_tests++;
    if (body_q.size() != 50 || bad != 0) begin
      n_fail++;
      $display("FAIL rstmid_body: count=%0d wrong=%0d required 50/0", body_q.size(), bad);
    end
    n_tests++;
    if (h_cnt != 1 || h_last[155] !== 1'b0 || h_last[154:144] !== 11'd50) begin
      n_fail++;
      $display("FAIL rstmid_hdr: hwren=%0d tagged=%b len=%0d required 1/0/50", h_cnt, h_last[155], h_last[154:144]);
    end
    n_tests++;
    if (ok_cnt !== 16'd1 || err_cnt !== 16'd0 || drop_cnt != 0) begin
      n_fail++;
      $display("FAIL rstmid_cnts: ok=%0d err=%0d drop=%0d required 1/0/0", ok_cnt, err_cnt, drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_untagged();
    test_tagged();
    test_runt();
    test_oversize();
    test_stall_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
